// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants, scheduler state encoding and helper
//               functions for the HD44780 character scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // HD44780 instruction bytes
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] ADDR_LINE1   = 8'h80;
    localparam logic [7:0] ADDR_LINE2   = 8'hC0;

    localparam int LINE_LEN = 16;
    localparam int INIT_LEN = 5;

    // Control codes recognised when control-character handling is built in
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic [2:0] {
        ST_PWR  = 3'd0,
        ST_INIT = 3'd1,
        ST_IDLE = 3'd2,
        ST_CHAR = 3'd3,
        ST_ADDR = 3'd4,
        ST_CLR  = 3'd5
    } sched_state_t;

    // Power-on command sequence, indexed 0..INIT_LEN-1
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD_FUNC_SET;
            3'd1:    return CMD_DISP_ON;
            3'd2:    return CMD_CLEAR;
            3'd3:    return CMD_ENTRY;
            default: return ADDR_LINE1;
        endcase
    endfunction

    // Set-DDRAM-address command for a cursor position
    function automatic logic [7:0] addr_cmd(input logic row, input logic [3:0] col);
        return row ? (ADDR_LINE2 | {4'h0, col}) : (ADDR_LINE1 | {4'h0, col});
    endfunction

    function automatic logic is_ctrl_code(input logic [7:0] b);
        return (b == CH_LF) || (b == CH_CR) || (b == CH_FF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_char_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_sched_if
// Description : Byte-stream handshake plus LCD pin bundle for the character
//               scheduler. slave = scheduler side, master = byte source/pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_char_sched_if;
    logic [7:0] idata;
    logic       ivalid;
    logic       oready;
    logic       oinit_done;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    modport master (
        output idata, ivalid,
        input  oready, oinit_done, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );

    modport slave (
        input  idata, ivalid,
        output oready, oinit_done, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_phy.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_phy
// Description : One LCD write transaction per start: a setup cycle, then
//               EN_PULSE_CYC cycles of EN high, then CMD_WAIT_CYC cycles of
//               wait. o_done pulses in the last wait cycle so a new start in
//               that cycle follows with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_phy #(
    parameter int EN_PULSE_CYC = 24,
    parameter int CMD_WAIT_CYC = 82433
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_start,
    input  wire logic       i_rs,
    input  wire logic [7:0] i_data,
    output logic            o_done,
    output logic [7:0]      o_lcd_data,
    output logic            o_lcd_rs,
    output logic            o_lcd_en
);

    localparam int c_tx_len = 1 + EN_PULSE_CYC + CMD_WAIT_CYC;
    localparam int c_cnt_w  = $clog2(c_tx_len);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_tx_len - 1);
    localparam logic [c_cnt_w-1:0] c_en_last = c_cnt_w'(EN_PULSE_CYC);

    logic               r_active_q, w_active_d;
    logic [c_cnt_w-1:0] r_cnt_q,    w_cnt_d;
    logic [7:0]         r_data_q,   w_data_d;
    logic               r_rs_q,     w_rs_d;
    logic               r_en_q,     w_en_d;

    assign o_done     = r_active_q && (r_cnt_q == c_last);
    assign o_lcd_data = r_data_q;
    assign o_lcd_rs   = r_rs_q;
    assign o_lcd_en   = r_en_q;

    // Phase counter: 0 = setup, 1..EN_PULSE_CYC = EN high, rest = wait
    always_comb begin
        w_active_d = r_active_q;
        w_cnt_d    = r_cnt_q;
        w_data_d   = r_data_q;
        w_rs_d     = r_rs_q;
        if (r_active_q) begin
            if (o_done) begin
                w_active_d = 1'b0;
            end else begin
                w_cnt_d = r_cnt_q + c_cnt_w'(1);
            end
        end
        if (i_start) begin
            w_active_d = 1'b1;
            w_cnt_d    = '0;
            w_data_d   = i_data;
            w_rs_d     = i_rs;
        end
        w_en_d = w_active_d && (w_cnt_d != '0) && (w_cnt_d <= c_en_last);
    end

    // Registered pins and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_q <= 1'b0;
            r_cnt_q    <= '0;
            r_data_q   <= 8'h00;
            r_rs_q     <= 1'b0;
            r_en_q     <= 1'b0;
        end else begin
            r_active_q <= w_active_d;
            r_cnt_q    <= w_cnt_d;
            r_data_q   <= w_data_d;
            r_rs_q     <= w_rs_d;
            r_en_q     <= w_en_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_char_sched.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_sched
// Description : HD44780 16x2 character scheduler. Runs the power-on init,
//               accepts bytes on a valid/ready handshake, tracks the cursor
//               and inserts DDRAM-address commands at line ends.
//               Build macro LCD_CTRL_CHAR_EN: when defined, 0x0A/0x0D/0x0C
//               act as newline / carriage return / form feed; otherwise
//               every byte is written as display data.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_char_sched
    import lcd_pkg::*;
#(
    parameter int EN_PULSE_CYC   = 24,
    parameter int CMD_WAIT_CYC   = 82433,
    parameter int PWRON_WAIT_CYC = 2000000
) (
    input  wire logic        iclk,
    input  wire logic        irst,
    lcd_char_sched_if.slave  bus
);

    localparam int c_pwr_w = $clog2(PWRON_WAIT_CYC + 1);
    localparam logic [c_pwr_w-1:0] c_pwr_last = c_pwr_w'(PWRON_WAIT_CYC - 1);
    localparam logic [3:0]         c_col_last = 4'(LINE_LEN - 1);
    localparam logic [2:0]         c_init_last = 3'(INIT_LEN - 1);

    sched_state_t       r_state_q,     w_state_d;
    logic [c_pwr_w-1:0] r_pwr_cnt_q,   w_pwr_cnt_d;
    logic [2:0]         r_init_idx_q,  w_init_idx_d;
    logic               r_row_q,       w_row_d;
    logic [3:0]         r_col_q,       w_col_d;
    logic               r_oready_q,    w_oready_d;
    logic               r_init_done_q, w_init_done_d;

    logic       w_start;
    logic       w_start_rs;
    logic [7:0] w_start_data;
    logic       w_phy_done;
    logic       w_ctrl_en;

`ifdef LCD_CTRL_CHAR_EN
    assign w_ctrl_en = 1'b1;
`else
    assign w_ctrl_en = 1'b0;
`endif

    assign bus.oready     = r_oready_q;
    assign bus.oinit_done = r_init_done_q;
    assign bus.LCD_RW     = 1'b0;

    lcd_bus_phy #(
        .EN_PULSE_CYC (EN_PULSE_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC)
    ) u_phy (
        .clk        (iclk),
        .rst        (irst),
        .i_start    (w_start),
        .i_rs       (w_start_rs),
        .i_data     (w_start_data),
        .o_done     (w_phy_done),
        .o_lcd_data (bus.LCD_DATA),
        .o_lcd_rs   (bus.LCD_RS),
        .o_lcd_en   (bus.LCD_EN)
    );

    // Next state, cursor update and transaction launch; a new transaction
    // is started in the same cycle the previous one reports done.
    always_comb begin
        w_state_d     = r_state_q;
        w_pwr_cnt_d   = r_pwr_cnt_q;
        w_init_idx_d  = r_init_idx_q;
        w_row_d       = r_row_q;
        w_col_d       = r_col_q;
        w_oready_d    = 1'b0;
        w_init_done_d = r_init_done_q;
        w_start       = 1'b0;
        w_start_rs    = 1'b0;
        w_start_data  = 8'h00;
        case (r_state_q)
            ST_PWR: begin
                if (r_pwr_cnt_q == c_pwr_last) begin
                    w_state_d    = ST_INIT;
                    w_init_idx_d = 3'd0;
                    w_start      = 1'b1;
                    w_start_data = init_cmd(3'd0);
                end else begin
                    w_pwr_cnt_d = r_pwr_cnt_q + c_pwr_w'(1);
                end
            end
            ST_INIT: begin
                if (w_phy_done) begin
                    if (r_init_idx_q == c_init_last) begin
                        w_state_d     = ST_IDLE;
                        w_oready_d    = 1'b1;
                        w_init_done_d = 1'b1;
                        w_row_d       = 1'b0;
                        w_col_d       = 4'd0;
                    end else begin
                        w_init_idx_d = r_init_idx_q + 3'd1;
                        w_start      = 1'b1;
                        w_start_data = init_cmd(r_init_idx_q + 3'd1);
                    end
                end
            end
            ST_IDLE: begin
                w_oready_d = 1'b1;
                if (bus.ivalid && r_oready_q) begin
                    w_oready_d = 1'b0;
                    w_start    = 1'b1;
                    if (w_ctrl_en && is_ctrl_code(bus.idata)) begin
                        if (bus.idata == CH_LF) begin
                            w_row_d      = ~r_row_q;
                            w_col_d      = 4'd0;
                            w_start_data = addr_cmd(~r_row_q, 4'd0);
                            w_state_d    = ST_ADDR;
                        end else if (bus.idata == CH_CR) begin
                            w_col_d      = 4'd0;
                            w_start_data = addr_cmd(r_row_q, 4'd0);
                            w_state_d    = ST_ADDR;
                        end else begin
                            w_row_d      = 1'b0;
                            w_col_d      = 4'd0;
                            w_start_data = CMD_CLEAR;
                            w_state_d    = ST_CLR;
                        end
                    end else begin
                        w_start_rs   = 1'b1;
                        w_start_data = bus.idata;
                        w_state_d    = ST_CHAR;
                    end
                end
            end
            ST_CHAR: begin
                if (w_phy_done) begin
                    if (r_col_q == c_col_last) begin
                        // Line end: jump to the start of the other line
                        w_col_d      = 4'd0;
                        w_row_d      = ~r_row_q;
                        w_start      = 1'b1;
                        w_start_data = addr_cmd(~r_row_q, 4'd0);
                        w_state_d    = ST_ADDR;
                    end else begin
                        w_col_d    = r_col_q + 4'd1;
                        w_state_d  = ST_IDLE;
                        w_oready_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_phy_done) begin
                    w_state_d  = ST_IDLE;
                    w_oready_d = 1'b1;
                end
            end
            ST_CLR: begin
                if (w_phy_done) begin
                    w_start      = 1'b1;
                    w_start_data = addr_cmd(1'b0, 4'd0);
                    w_state_d    = ST_ADDR;
                end
            end
            default: begin
                w_state_d = ST_PWR;
            end
        endcase
    end

    // Scheduler state, cursor and registered handshake outputs
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state_q     <= ST_PWR;
            r_pwr_cnt_q   <= '0;
            r_init_idx_q  <= 3'd0;
            r_row_q       <= 1'b0;
            r_col_q       <= 4'd0;
            r_oready_q    <= 1'b0;
            r_init_done_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_pwr_cnt_q   <= w_pwr_cnt_d;
            r_init_idx_q  <= w_init_idx_d;
            r_row_q       <= w_row_d;
            r_col_q       <= w_col_d;
            r_oready_q    <= w_oready_d;
            r_init_done_q <= w_init_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_char_sched
// Description : Self-checking bench for lcd_char_sched. A monitor records
//               every EN pulse; a stream model derived from the display
//               rules predicts the pulse sequence for the bytes accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_char_sched;

`ifdef LCD_CTRL_CHAR_EN
    localparam bit CTRL_EN = 1'b1;
`else
    localparam bit CTRL_EN = 1'b0;
`endif
    localparam int T_TX = 15;
    localparam int INIT_LAT = 20 + 5 * T_TX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_char_sched_if bus ();

    lcd_char_sched #(
        .EN_PULSE_CYC   (4),
        .CMD_WAIT_CYC   (10),
        .PWRON_WAIT_CYC (20)
    ) dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         width;
        bit         stable;
        int         rise;
    } pulse_t;

    pulse_t     pulses[$];
    logic [8:0] exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         m_row, m_col;

    // Pulse monitor: samples on the falling edge
    initial begin
        pulse_t     cur;
        logic       en_prev = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       prev_rs = 1'b0;
        cur = '{rs: 1'b0, data: 8'h00, width: 0, stable: 1'b0, rise: 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.LCD_EN === 1'b1 && !en_prev) begin
                cur.rs     = bus.LCD_RS;
                cur.data   = bus.LCD_DATA;
                cur.width  = 1;
                cur.stable = (bus.LCD_DATA === prev_data) && (bus.LCD_RS === prev_rs);
                cur.rise   = cyc;
            end else if (bus.LCD_EN === 1'b1) begin
                cur.width++;
                if (bus.LCD_DATA !== cur.data || bus.LCD_RS !== cur.rs) cur.stable = 1'b0;
            end else if (en_prev) begin
                pulses.push_back(cur);
            end
            en_prev   = (bus.LCD_EN === 1'b1);
            prev_data = bus.LCD_DATA;
            prev_rs   = bus.LCD_RS;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] line_base(input int row);
        return (row != 0) ? 8'hC0 : 8'h80;
    endfunction

    function automatic void model_reset();
        logic [7:0] seq [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
        foreach (seq[i]) exp_q.push_back({1'b0, seq[i]});
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (CTRL_EN && b == 8'h0A) begin
            m_row = 1 - m_row;
            m_col = 0;
            exp_q.push_back({1'b0, line_base(m_row)});
        end else if (CTRL_EN && b == 8'h0D) begin
            m_col = 0;
            exp_q.push_back({1'b0, line_base(m_row)});
        end else if (CTRL_EN && b == 8'h0C) begin
            exp_q.push_back({1'b0, 8'h01});
            exp_q.push_back({1'b0, 8'h80});
            m_row = 0;
            m_col = 0;
        end else begin
            exp_q.push_back({1'b1, b});
            m_col++;
            if (m_col == 16) begin
                m_col = 0;
                m_row = 1 - m_row;
                exp_q.push_back({1'b0, line_base(m_row)});
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max, output int c);
        c = 0;
        while (bus.oready !== 1'b1 && c < max) begin
            tick();
            c++;
        end
        if (bus.oready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_ready: oready=%b after %0d cycles, required 1", bus.oready, c);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int c;
        wait_ready(1000, c);
        bus.idata  = b;
        bus.ivalid = 1'b1;
        tick();
        bus.ivalid = 1'b0;
        model_byte(b);
    endtask

    task automatic reset_dut();
        int c;
        rst = 1'b1;
        bus.ivalid = 1'b0;
        bus.idata  = 8'h00;
        repeat (3) tick();
        pulses.delete();
        exp_q.delete();
        model_reset();
        rst = 1'b0;
        wait_ready(300, c);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int c, cyc0;
        rst = 1'b1;
        bus.ivalid = 1'b0;
        bus.idata  = 8'h00;
        tick();
        tick();
        n_cmp++; if (bus.oready !== 1'b0)     begin n_fail++; $display("FAIL reset_oready: got %b want 0", bus.oready); end
        n_cmp++; if (bus.oinit_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", bus.oinit_done); end
        n_cmp++; if (bus.LCD_EN !== 1'b0)     begin n_fail++; $display("FAIL reset_en: got %b want 0", bus.LCD_EN); end
        n_cmp++; if (bus.LCD_DATA !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %02h want 00", bus.LCD_DATA); end
        n_cmp++; if (bus.LCD_RS !== 1'b0)     begin n_fail++; $display("FAIL reset_rs: got %b want 0", bus.LCD_RS); end
        n_cmp++; if (bus.LCD_RW !== 1'b0)     begin n_fail++; $display("FAIL reset_rw: got %b want 0", bus.LCD_RW); end
        pulses.delete();
        exp_q.delete();
        model_reset();
        cyc0 = cyc;
        rst = 1'b0;
        wait_ready(300, c);
        n_cmp++;
        if (c < INIT_LAT || c > INIT_LAT + 1) begin
            n_fail++;
            $display("FAIL init_latency: got %0d cycles want %0d..%0d", c, INIT_LAT, INIT_LAT + 1);
        end
        n_cmp++;
        if (bus.oinit_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1", bus.oinit_done); end
        if (pulses.size() > 0) begin
            n_cmp++;
            if (pulses[0].rise - cyc0 <= 20 || pulses[0].rise - cyc0 > 22) begin
                n_fail++;
                $display("FAIL pwr_wait: first EN after %0d cycles want 21..22", pulses[0].rise - cyc0);
            end
        end
        for (int i = 1; i < pulses.size(); i++) begin
            n_cmp++;
            if (pulses[i].rise - pulses[i-1].rise != T_TX) begin
                n_fail++;
                $display("FAIL init_spacing[%0d]: got %0d want %0d", i, pulses[i].rise - pulses[i-1].rise, T_TX);
            end
        end
        n_cmp++;
        if (pulses.size() != exp_q.size()) begin n_fail++; $display("FAIL init_count: got %0d pulses want %0d", pulses.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
            n_cmp++;
            if ({pulses[i].rs, pulses[i].data} !== exp_q[i] || pulses[i].width != 4 || !pulses[i].stable) begin
                n_fail++;
                $display("FAIL init_pulse[%0d]: got rs=%0b data=%02h width=%0d stable=%0b want rs=%0b data=%02h width=4 stable=1",
                         i, pulses[i].rs, pulses[i].data, pulses[i].width, pulses[i].stable, exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_single_char();
        int c;
        reset_dut();
        send_byte(8'h41);
        wait_ready(100, c);
        n_cmp++;
        if (c != T_TX) begin n_fail++; $display("FAIL char_latency: got %0d want %0d", c, T_TX); end
        n_cmp++;
        if (pulses.size() != exp_q.size()) begin n_fail++; $display("FAIL char_count: got %0d pulses want %0d", pulses.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
            n_cmp++;
            if ({pulses[i].rs, pulses[i].data} !== exp_q[i] || pulses[i].width != 4 || !pulses[i].stable) begin
                n_fail++;
                $display("FAIL char_pulse[%0d]: got rs=%0b data=%02h width=%0d stable=%0b want rs=%0b data=%02h width=4 stable=1",
                         i, pulses[i].rs, pulses[i].data, pulses[i].width, pulses[i].stable, exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_line_wrap();
        int c;
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h30 + 8'(i));
            wait_ready(100, c);
            n_cmp++;
            if (c != ((i == 15) ? 2 * T_TX : T_TX)) begin
                n_fail++;
                $display("FAIL wrap_latency[%0d]: got %0d want %0d", i, c, (i == 15) ? 2 * T_TX : T_TX);
            end
        end
        for (int i = 0; i < 17; i++) send_byte(8'($urandom_range(32, 126)));
        wait_ready(100, c);
        n_cmp++;
        if (pulses.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d pulses want %0d", pulses.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
            n_cmp++;
            if ({pulses[i].rs, pulses[i].data} !== exp_q[i] || pulses[i].width != 4 || !pulses[i].stable) begin
                n_fail++;
                $display("FAIL wrap_pulse[%0d]: got rs=%0b data=%02h width=%0d stable=%0b want rs=%0b data=%02h width=4 stable=1",
                         i, pulses[i].rs, pulses[i].data, pulses[i].width, pulses[i].stable, exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_ctrl_chars();
        int c;
        reset_dut();
        send_byte(8'h41);
        send_byte(8'h0A);
        send_byte(8'h0C);
        wait_ready(100, c);
        n_cmp++;
        if (c != (CTRL_EN ? 2 * T_TX : T_TX)) begin
            n_fail++;
            $display("FAIL ff_latency: got %0d want %0d", c, CTRL_EN ? 2 * T_TX : T_TX);
        end
        n_cmp++;
        if (pulses.size() != exp_q.size()) begin n_fail++; $display("FAIL ctrl_count: got %0d pulses want %0d", pulses.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
            n_cmp++;
            if ({pulses[i].rs, pulses[i].data} !== exp_q[i] || pulses[i].width != 4 || !pulses[i].stable) begin
                n_fail++;
                $display("FAIL ctrl_pulse[%0d]: got rs=%0b data=%02h width=%0d stable=%0b want rs=%0b data=%02h width=4 stable=1",
                         i, pulses[i].rs, pulses[i].data, pulses[i].width, pulses[i].stable, exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_random();
        int c;
        logic [7:0] codes [3] = '{8'h0A, 8'h0D, 8'h0C};
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) send_byte(codes[$urandom_range(0, 2)]);
            else                           send_byte(8'($urandom));
        end
        wait_ready(100, c);
        n_cmp++;
        if (pulses.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d pulses want %0d", pulses.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
            n_cmp++;
            if ({pulses[i].rs, pulses[i].data} !== exp_q[i] || pulses[i].width != 4 || !pulses[i].stable) begin
                n_fail++;
                $display("FAIL rand_pulse[%0d]: got rs=%0b data=%02h width=%0d stable=%0b want rs=%0b data=%02h width=4 stable=1",
                         i, pulses[i].rs, pulses[i].data, pulses[i].width, pulses[i].stable, exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [7:0] b;
        reset_dut();
        bus.ivalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            b = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
            bus.idata = b;
            if (bus.oready === 1'b1) model_byte(b);
            tick();
        end
        bus.ivalid = 1'b0;
        wait_ready(100, c);
        n_cmp++;
        if (pulses.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d pulses want %0d", pulses.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
            n_cmp++;
            if ({pulses[i].rs, pulses[i].data} !== exp_q[i] || pulses[i].width != 4 || !pulses[i].stable) begin
                n_fail++;
                $display("FAIL b2b_pulse[%0d]: got rs=%0b data=%02h width=%0d stable=%0b want rs=%0b data=%02h width=4 stable=1",
                         i, pulses[i].rs, pulses[i].data, pulses[i].width, pulses[i].stable, exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        reset_dut();
        bus.idata  = 8'h41;
        bus.ivalid = 1'b1;
        tick();
        bus.ivalid = 1'b0;
        c = 0;
        while (bus.LCD_EN !== 1'b1 && c < 10) begin tick(); c++; end
        n_cmp++;
        if (bus.LCD_EN !== 1'b1) begin n_fail++; $display("FAIL mid_en_rise: got %b want 1", bus.LCD_EN); end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.LCD_EN !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_en: got %b want 0", bus.LCD_EN); end
        n_cmp++; if (bus.oready !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_oready: got %b want 0", bus.oready); end
        n_cmp++; if (bus.oinit_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_init_done: got %b want 0", bus.oinit_done); end
        tick();
        tick();
        pulses.delete();
        exp_q.delete();
        model_reset();
        rst = 1'b0;
        wait_ready(300, c);
        n_cmp++;
        if (c < INIT_LAT || c > INIT_LAT + 1) begin
            n_fail++;
            $display("FAIL mid_init_latency: got %0d want %0d..%0d", c, INIT_LAT, INIT_LAT + 1);
        end
        n_cmp++;
        if (pulses.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d pulses want %0d", pulses.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
            n_cmp++;
            if ({pulses[i].rs, pulses[i].data} !== exp_q[i] || pulses[i].width != 4 || !pulses[i].stable) begin
                n_fail++;
                $display("FAIL mid_pulse[%0d]: got rs=%0b data=%02h width=%0d stable=%0b want rs=%0b data=%02h width=4 stable=1",
                         i, pulses[i].rs, pulses[i].data, pulses[i].width, pulses[i].stable, exp_q[i][8], exp_q[i][7:0]);
            end
        end
    endtask

    initial begin
        bus.idata  = 8'h00;
        bus.ivalid = 1'b0;
        test_reset();
        test_single_char();
        test_line_wrap();
        test_ctrl_chars();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
